// File: rtl/matmul_flags_regs.sv
// matmul_flags_regs: sticky overflow flag register file with mask, event counter and bus read port
module matmul_flags_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flag_valid_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   flag_set_i,
  input  logic [1:0]                   addr_i,
  input  logic                         write_en_i,
  input  logic                         read_en_i,
  input  logic [BUS_WIDTH-1:0]         wdata_i,
  output logic [BUS_WIDTH-1:0]         rdata_o,
  output logic                         rvalid_o,
  output logic [MAX_DIM*MAX_DIM-1:0]   flags_o,
  output logic                         irq_o
);
  localparam int NF = MAX_DIM * MAX_DIM;

  logic [NF-1:0]        r_flags;
  logic [NF-1:0]        r_mask;
  logic [CNT_WIDTH-1:0] r_count;
  logic [1:0]           r_ctrl;
  logic [BUS_WIDTH-1:0] r_rdata;
  logic                 r_rvalid;

  logic                 w_capture;
  logic [NF-1:0]        w_set;
  logic [NF-1:0]        w_clr;
  logic                 w_wr_flags;
  logic                 w_wr_mask;
  logic                 w_wr_count;
  logic                 w_wr_ctrl;
  logic                 w_rd_flags;
  logic [BUS_WIDTH-1:0] w_rd;
  logic                 w_unused;

  assign w_wr_flags = write_en_i && addr_i == 2'd0;
  assign w_wr_mask  = write_en_i && addr_i == 2'd1;
  assign w_wr_count = write_en_i && addr_i == 2'd2;
  assign w_wr_ctrl  = write_en_i && addr_i == 2'd3;
  assign w_rd_flags = read_en_i && addr_i == 2'd0;
  assign w_capture  = flag_valid_i && !r_ctrl[1];
  assign w_set      = w_capture ? flag_set_i : '0;
  // W1C and clear-on-read both clear; new sets are OR-ed in afterwards so they win
  assign w_clr      = (w_wr_flags ? wdata_i[NF-1:0] : '0) | (w_rd_flags && r_ctrl[0] ? r_flags : '0);
  assign w_unused   = ^wdata_i;

  // Zero-extended read mux over the pre-update register values
  always_comb begin
    w_rd = '0;
    case (addr_i)
      2'd0:    w_rd[NF-1:0] = r_flags;
      2'd1:    w_rd[NF-1:0] = r_mask;
      2'd2:    w_rd[CNT_WIDTH-1:0] = r_count;
      default: w_rd[1:0] = r_ctrl;
    endcase
  end

  // Register file state: sticky flags, mask, saturating event counter, control
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flags <= '0;
      r_mask  <= '1;
      r_count <= '0;
      r_ctrl  <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clr) | w_set;
      if (w_wr_mask) r_mask <= wdata_i[NF-1:0];
      if (w_wr_ctrl) r_ctrl <= wdata_i[1:0];
      if (w_wr_count) r_count <= '0;
      else if (w_capture && |flag_set_i && r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  // Registered read port: one result per read strobe, zero when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rdata  <= read_en_i ? w_rd : '0;
      r_rvalid <= read_en_i;
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign flags_o  = r_flags;
  assign irq_o    = |(r_flags & r_mask);
endmodule

// File: tb/tb_matmul_flags_regs.sv
// tb_matmul_flags_regs: vector table, randomized model comparison and reset corner cases
module tb_matmul_flags_regs;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flag_valid_i;
  logic [3:0]  flag_set_i;
  logic [1:0]  addr_i;
  logic        write_en_i;
  logic        read_en_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        rvalid_o;
  logic [3:0]  flags_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  int          m_flags, m_mask, m_count, m_ctrl;
  logic [63:0] exp_rdata;
  logic        exp_rvalid;

  typedef struct {
    logic v; logic [3:0] fs; logic [1:0] a; logic we; logic re; logic [63:0] wd;
    logic [3:0] ef; logic ei; logic [63:0] er; logic ev;
  } vec_t;
  vec_t tbl[28];

  matmul_flags_regs #(.CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flag_valid_i(flag_valid_i), .flag_set_i(flag_set_i),
    .addr_i(addr_i), .write_en_i(write_en_i), .read_en_i(read_en_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .flags_o(flags_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic model_reset();
    m_flags = 0; m_mask = 15; m_count = 0; m_ctrl = 0;
  endtask

  // Drive one cycle, advance the reference model, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic [3:0] fs, input logic [1:0] a,
                      input logic we, input logic re, input logic [63:0] wd);
    int set, clr, rv;
    flag_valid_i = v; flag_set_i = fs; addr_i = a; write_en_i = we; read_en_i = re; wdata_i = wd;
    rv = (a == 0) ? m_flags : (a == 1) ? m_mask : (a == 2) ? m_count : m_ctrl;
    exp_rdata  = re ? 64'(rv) : 64'd0;
    exp_rvalid = re;
    set = (v && (m_ctrl & 2) == 0) ? int'(fs) : 0;
    clr = ((we && a == 0) ? int'(wd[3:0]) : 0) | ((re && a == 0 && (m_ctrl & 1) != 0) ? m_flags : 0);
    m_flags = ((m_flags & ~clr) | set) & 15;
    if (we && a == 2) m_count = 0;
    else if (set != 0 && m_count < 15) m_count = m_count + 1;
    if (we && a == 1) m_mask = int'(wd[3:0]);
    if (we && a == 3) m_ctrl = int'(wd[1:0]);
    @(posedge clk_i);
    #1;
    flag_valid_i = 0; write_en_i = 0; read_en_i = 0;
  endtask

  initial begin
    tbl[0]  = '{0, 4'h0, 2'd1, 0, 1, 64'h0, 4'h0, 0, 64'hF, 1};
    tbl[1]  = '{0, 4'h0, 2'd2, 0, 1, 64'h0, 4'h0, 0, 64'h0, 1};
    tbl[2]  = '{1, 4'h5, 2'd0, 0, 0, 64'h0, 4'h5, 1, 64'h0, 0};
    tbl[3]  = '{0, 4'h0, 2'd2, 0, 1, 64'h0, 4'h5, 1, 64'h1, 1};
    tbl[4]  = '{0, 4'h0, 2'd0, 1, 0, 64'h1, 4'h4, 1, 64'h0, 0};
    tbl[5]  = '{1, 4'h4, 2'd0, 1, 0, 64'h4, 4'h4, 1, 64'h0, 0};
    tbl[6]  = '{0, 4'h0, 2'd1, 1, 0, 64'h0, 4'h4, 0, 64'h0, 0};
    tbl[7]  = '{0, 4'h0, 2'd1, 1, 0, 64'hF, 4'h4, 1, 64'h0, 0};
    tbl[8]  = '{0, 4'h0, 2'd0, 1, 0, 64'hF, 4'h0, 0, 64'h0, 0};
    tbl[9]  = '{1, 4'hA, 2'd0, 0, 0, 64'h0, 4'hA, 1, 64'h0, 0};
    tbl[10] = '{0, 4'h0, 2'd3, 1, 0, 64'h1, 4'hA, 1, 64'h0, 0};
    tbl[11] = '{0, 4'h0, 2'd0, 0, 1, 64'h0, 4'h0, 0, 64'hA, 1};
    tbl[12] = '{1, 4'h5, 2'd0, 0, 0, 64'h0, 4'h5, 1, 64'h0, 0};
    tbl[13] = '{1, 4'h1, 2'd0, 0, 1, 64'h0, 4'h1, 1, 64'h5, 1};
    tbl[14] = '{0, 4'h0, 2'd1, 1, 1, 64'h3, 4'h1, 1, 64'hF, 1};
    tbl[15] = '{0, 4'h0, 2'd1, 0, 1, 64'h0, 4'h1, 1, 64'h3, 1};
    tbl[16] = '{1, 4'h2, 2'd2, 1, 0, 64'h0, 4'h3, 1, 64'h0, 0};
    tbl[17] = '{0, 4'h0, 2'd2, 0, 1, 64'h0, 4'h3, 1, 64'h0, 1};
    tbl[18] = '{0, 4'h0, 2'd3, 0, 1, 64'h0, 4'h3, 1, 64'h1, 1};
    tbl[19] = '{0, 4'h0, 2'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1, 64'h0, 0};
    tbl[20] = '{0, 4'h0, 2'd3, 0, 1, 64'h0, 4'h3, 1, 64'h2, 1};
    tbl[21] = '{1, 4'hF, 2'd0, 0, 0, 64'h0, 4'h3, 1, 64'h0, 0};
    tbl[22] = '{1, 4'hC, 2'd0, 0, 0, 64'h0, 4'h3, 1, 64'h0, 0};
    tbl[23] = '{1, 4'h4, 2'd0, 0, 0, 64'h0, 4'h3, 1, 64'h0, 0};
    tbl[24] = '{0, 4'h0, 2'd2, 0, 1, 64'h0, 4'h3, 1, 64'h0, 1};
    tbl[25] = '{0, 4'h0, 2'd3, 1, 0, 64'h0, 4'h3, 1, 64'h0, 0};
    tbl[26] = '{0, 4'h0, 2'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4'h3, 1, 64'h0, 0};
    tbl[27] = '{0, 4'h0, 2'd0, 0, 1, 64'h0, 4'h3, 1, 64'h3, 1};

    rst_ni = 1'b0; flag_valid_i = 0; flag_set_i = 0; addr_i = 0;
    write_en_i = 0; read_en_i = 0; wdata_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_rdata", rdata_o, 64'h0);
    chk("reset_rvalid", 64'(rvalid_o), 64'h0);
    chk("reset_irq", 64'(irq_o), 64'h0);
    chk("reset_flags", 64'(flags_o), 64'h0);
    rst_ni = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].fs, tbl[k].a, tbl[k].we, tbl[k].re, tbl[k].wd);
      chk($sformatf("vec%0d_flags", k), 64'(flags_o), 64'(tbl[k].ef));
      chk($sformatf("vec%0d_irq", k), 64'(irq_o), 64'(tbl[k].ei));
      chk($sformatf("vec%0d_rdata", k), rdata_o, tbl[k].er);
      chk($sformatf("vec%0d_rvalid", k), 64'(rvalid_o), 64'(tbl[k].ev));
    end

    // Counter saturation: clear, then 20 qualifying cycles on a 4-bit counter
    step(0, 4'h0, 2'd3, 1, 0, 64'h0);
    step(0, 4'h0, 2'd2, 1, 0, 64'h0);
    for (int i = 0; i < 20; i++) step(1, 4'(1 + i % 15), 2'd0, 0, 0, 64'h0);
    step(0, 4'h0, 2'd2, 0, 1, 64'h0);
    chk("sat_count", rdata_o, 64'd15);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 4'($urandom), 2'($urandom), ($urandom % 4) == 0, 1'($urandom),
           {$urandom, $urandom});
      chk($sformatf("rnd%0d_flags", i), 64'(flags_o), 64'(m_flags));
      chk($sformatf("rnd%0d_irq", i), 64'(irq_o), 64'((m_flags & m_mask) != 0));
      chk($sformatf("rnd%0d_rdata", i), rdata_o, exp_rdata);
      chk($sformatf("rnd%0d_rvalid", i), 64'(rvalid_o), 64'(exp_rvalid));
    end

    // Asynchronous reset right after a read is issued
    step(0, 4'h0, 2'd3, 1, 0, 64'h0);
    step(1, 4'hF, 2'd1, 1, 0, 64'h5);
    step(0, 4'h0, 2'd1, 0, 1, 64'h0);
    chk("pre_rst_rvalid", 64'(rvalid_o), 64'h1);
    chk("pre_rst_rdata", rdata_o, 64'h5);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_rvalid", 64'(rvalid_o), 64'h0);
    chk("arst_rdata", rdata_o, 64'h0);
    chk("arst_flags", 64'(flags_o), 64'h0);
    chk("arst_irq", 64'(irq_o), 64'h0);
    #1 rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    step(0, 4'h0, 2'd1, 0, 1, 64'h0);
    chk("post_rst_mask", rdata_o, 64'hF);
    step(0, 4'h0, 2'd2, 0, 1, 64'h0);
    chk("post_rst_count", rdata_o, 64'h0);
    step(0, 4'h0, 2'd3, 0, 1, 64'h0);
    chk("post_rst_ctrl", rdata_o, 64'h0);
    step(0, 4'h0, 2'd0, 0, 0, 64'h0);
    chk("post_rst_rvalid", 64'(rvalid_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
